// File: rtl/operand_fetch.sv
// operand_fetch -- operand-fetch stage of the 8-bit CPU datapath.
//
// Holds the NREGS x WIDTH general register bank. Each accepted request reads
// two registers (with write-first bypass from the writeback port) into a
// one-deep output buffer that is drained with a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   wrEn/wrAddr/wrData  writeback port (independent of the handshake)
//   reqValid/reqReady   fetch request handshake
//   rdAddrA/rdAddrB     source register indices
//   outValid/outReady   output buffer handshake
//   opA/opB             buffered operand pair

// One read port: register bank lookup with same-cycle write bypass.
module operand_fetch_rdport #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic                        wrEn,
  input  logic [ADDR_W-1:0]           wrAddr,
  input  logic [WIDTH-1:0]            wrData,
  input  logic [ADDR_W-1:0]           rdAddr,
  output logic [WIDTH-1:0]            rdData
);
  assign rdData = (wrEn && (wrAddr == rdAddr)) ? wrData : regs[rdAddr];
endmodule

module operand_fetch #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              outValid,
  input  logic              outReady,
  output logic [WIDTH-1:0]  opA,
  output logic [WIDTH-1:0]  opB
);
  localparam int NPORTS = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bufState_t;

  bufState_t state, stateNext;
  logic      accept, loadOps;

  logic [NREGS-1:0][WIDTH-1:0]  regs;
  logic [NPORTS-1:0][ADDR_W-1:0] rdAddr;
  logic [NPORTS-1:0][WIDTH-1:0]  rdData;
  logic [NPORTS-1:0][WIDTH-1:0]  opBuf;

  // reqReady depends only on buffer state and outReady, never on reqValid.
  assign reqReady = (state == EMPTY) || outReady;
  assign accept   = reqValid && reqReady && !rst;
  assign outValid = (state == FULL);

  always_comb begin
    stateNext = state;
    loadOps   = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        stateNext = FULL;
        loadOps   = 1'b1;
      end
      FULL: if (outReady) begin
        // Consumed this cycle: refill back-to-back or drain.
        if (accept) loadOps   = 1'b1;
        else        stateNext = EMPTY;
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= stateNext;
  end

  // Register bank write port; runs regardless of buffer state.
  always_ff @(posedge clk) begin
    if (rst)       regs         <= '0;
    else if (wrEn) regs[wrAddr] <= wrData;
  end

  assign rdAddr = {rdAddrB, rdAddrA};

  for (genvar g = 0; g < NPORTS; g++) begin : gRd
    operand_fetch_rdport #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W)
    ) uRd (
      .regs  (regs),
      .wrEn  (wrEn),
      .wrAddr(wrAddr),
      .wrData(wrData),
      .rdAddr(rdAddr[g]),
      .rdData(rdData[g])
    );
  end

  // Operands are a snapshot taken at accept; later writes do not touch them.
  always_ff @(posedge clk) begin
    if (rst)          opBuf <= '0;
    else if (loadOps) opBuf <= rdData;
  end

  assign opA = opBuf[0];
  assign opB = opBuf[1];
endmodule
